// File: rtl/sccpu_regfile.sv
// sccpu_regfile: 2**AW x WIDTH general-purpose register file for the
// single-cycle CPU datapath.
//   Write port : we / wa / wd. The address is decoded to a one-hot enable and
//                commits on the rising clk edge. r[0] is hardwired to zero.
//   Read ports : rd0 <- ra0 and rd1 <- ra1 are combinational ALU operand
//                reads. When BYPASS=1 they forward wd on an address match.
//   Debug port : dbg_rd <- dbg_ra is combinational and never bypassed.
//   wr_cnt     : saturating count of committed writes to nonzero registers.
//   rst        : asynchronous, active-high. Clears every register and wr_cnt.

// One storage register. It is instantiated once per nonzero address.
module sccpu_regfile_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

module sccpu_regfile #(
  parameter int WIDTH  = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra0,
  output logic [WIDTH-1:0] rd0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd1,
  input  logic [AW-1:0]    dbg_ra,
  output logic [WIDTH-1:0] dbg_rd,
  output logic [15:0]      wr_cnt
);
  localparam int NREG = 2**AW;

  logic [NREG-1:0]            wen;
  logic [NREG-1:0][WIDTH-1:0] r;
  logic                       wr_nz;

  // Any enabled write to a nonzero address. This drives both the counter
  // and the bypass qualifier.
  assign wr_nz = we & (wa != '0);

  genvar i;
  generate
    for (i = 0; i < NREG; i++) begin : g_reg
      if (i == 0) begin : g_zero
        assign wen[i] = 1'b0;
        assign r[i]   = '0;
      end else begin : g_store
        // Gating the compare with we keeps an unknown wa from reaching any
        // enable while no write is in progress.
        assign wen[i] = we & (wa == AW'(i));
        sccpu_regfile_reg #(.WIDTH(WIDTH)) u_reg (
          .clk (clk),
          .rst (rst),
          .en  (wen[i]),
          .d   (wd),
          .q   (r[i])
        );
      end
    end
  endgenerate

  // r[0] is constant zero, so the explicit zero select only documents intent.
  logic [WIDTH-1:0] arr0, arr1;
  assign arr0   = (ra0    == '0) ? '0 : r[ra0];
  assign arr1   = (ra1    == '0) ? '0 : r[ra1];
  assign dbg_rd = (dbg_ra == '0) ? '0 : r[dbg_ra];

  generate
    if (BYPASS) begin : g_byp
      assign rd0 = (wr_nz && (wa == ra0)) ? wd : arr0;
      assign rd1 = (wr_nz && (wa == ra1)) ? wd : arr1;
    end else begin : g_nobyp
      assign rd0 = arr0;
      assign rd1 = arr1;
    end
  endgenerate

  // The counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             wr_cnt <= '0;
    else if (wr_nz && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
  end
endmodule

// File: tb/tb_sccpu_regfile.sv
// Directed bench for sccpu_regfile. A BYPASS=0 instance (u0) and a BYPASS=1
// instance (u1) share every input, so each check can compare both variants.
module tb_sccpu_regfile;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [4:0]  wa  = '0;
  logic [31:0] wd  = '0;
  logic [4:0]  ra0 = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  dbg_ra = '0;
  logic [31:0] rd0_a, rd1_a, dbg_a, rd0_b, rd1_b, dbg_b;
  logic [15:0] cnt_a, cnt_b;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sccpu_regfile #(.WIDTH(32), .AW(5), .BYPASS(1'b0)) u0 (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra0(ra0), .rd0(rd0_a), .ra1(ra1), .rd1(rd1_a),
    .dbg_ra(dbg_ra), .dbg_rd(dbg_a), .wr_cnt(cnt_a));

  sccpu_regfile #(.WIDTH(32), .AW(5), .BYPASS(1'b1)) u1 (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra0(ra0), .rd0(rd0_b), .ra1(ra1), .rd1(rd1_b),
    .dbg_ra(dbg_ra), .dbg_rd(dbg_b), .wr_cnt(cnt_b));

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); we = 1'b1; wa = a; wd = d;
    @(posedge clk); #1; we = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    tests++; if (rd0_a !== 32'h0 || rd1_a !== 32'h0 || dbg_a !== 32'h0) begin
      fails++; $display("FAIL reset_reads got %h %h %h want 0", rd0_a, rd1_a, dbg_a); end
    tests++; if (cnt_a !== 16'h0 || cnt_b !== 16'h0) begin
      fails++; $display("FAIL reset_cnt got %h/%h want 0", cnt_a, cnt_b); end
    @(negedge clk); rst = 1'b0;
    write_reg(5'd5, 32'h1234);
    ra0 = 5'd5; #1;
    tests++; if (rd0_a !== 32'h1234) begin
      fails++; $display("FAIL load_r5 got %h want 00001234", rd0_a); end
    // Assert reset mid-cycle and check the clear before any clock edge.
    rst = 1'b1; #1;
    tests++; if (rd0_a !== 32'h0 || rd0_b !== 32'h0) begin
      fails++; $display("FAIL async_clear got %h/%h want 0", rd0_a, rd0_b); end
    tests++; if (cnt_a !== 16'h0) begin
      fails++; $display("FAIL async_cnt got %h want 0", cnt_a); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_walk;
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hA5A50000 + 32'(i));
    for (int i = 1; i < 32; i++) begin
      ra0 = 5'(i); ra1 = 5'(i); dbg_ra = 5'(i); #1;
      tests++; if (rd0_a !== 32'hA5A50000 + 32'(i) || rd1_a !== 32'hA5A50000 + 32'(i) ||
                   dbg_a !== 32'hA5A50000 + 32'(i) || rd0_b !== 32'hA5A50000 + 32'(i)) begin
        fails++; $display("FAIL walk_r%0d got %h %h %h %h want %h", i, rd0_a, rd1_a, dbg_a,
                          rd0_b, 32'hA5A50000 + 32'(i)); end
    end
    tests++; if (cnt_a !== 16'd31 || cnt_b !== 16'd31) begin
      fails++; $display("FAIL walk_cnt got %0d/%0d want 31", cnt_a, cnt_b); end
  endtask

  task automatic test_zero_reg;
    write_reg(5'd0, 32'hFFFFFFFF);
    ra0 = 5'd0; dbg_ra = 5'd0; #1;
    tests++; if (rd0_a !== 32'h0 || rd0_b !== 32'h0 || dbg_a !== 32'h0) begin
      fails++; $display("FAIL zero_reg got %h %h %h want 0", rd0_a, rd0_b, dbg_a); end
    tests++; if (cnt_a !== 16'd31) begin
      fails++; $display("FAIL zero_cnt got %0d want 31", cnt_a); end
  endtask

  task automatic test_rdw;
    write_reg(5'd7, 32'h11);
    @(negedge clk); we = 1'b1; wa = 5'd7; wd = 32'h22; ra0 = 5'd7; ra1 = 5'd7; dbg_ra = 5'd7; #1;
    tests++; if (rd1_a !== 32'h11 || rd0_a !== 32'h11) begin
      fails++; $display("FAIL rdw_nobyp got %h/%h want 00000011", rd1_a, rd0_a); end
    tests++; if (rd1_b !== 32'h22 || rd0_b !== 32'h22) begin
      fails++; $display("FAIL rdw_byp got %h/%h want 00000022", rd1_b, rd0_b); end
    tests++; if (dbg_b !== 32'h11) begin
      fails++; $display("FAIL rdw_dbg got %h want 00000011", dbg_b); end
    @(posedge clk); #1; we = 1'b0; #1;
    tests++; if (rd1_a !== 32'h22 || rd1_b !== 32'h22 || dbg_a !== 32'h22) begin
      fails++; $display("FAIL rdw_after got %h %h %h want 00000022", rd1_a, rd1_b, dbg_a); end
  endtask

  task automatic test_mid_reset;
    @(negedge clk); we = 1'b1; wa = 5'd9; wd = 32'hDEAD; #1;
    rst = 1'b1;
    // Reset is held through the edge, so the pending write must be dropped.
    @(negedge clk); rst = 1'b0; we = 1'b0; ra0 = 5'd9; #1;
    tests++; if (rd0_a !== 32'h0 || rd0_b !== 32'h0) begin
      fails++; $display("FAIL mid_reset_r9 got %h/%h want 0", rd0_a, rd0_b); end
    tests++; if (cnt_a !== 16'h0) begin
      fails++; $display("FAIL mid_reset_cnt got %0d want 0", cnt_a); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); we = 1'b1; wa = 5'd4; wd = 32'h1;
    @(negedge clk); wd = 32'h2;
    @(negedge clk); wd = 32'h3;
    @(posedge clk); #1; we = 1'b0; ra0 = 5'd4; #1;
    tests++; if (rd0_a !== 32'h3) begin
      fails++; $display("FAIL b2b_data got %h want 00000003", rd0_a); end
    tests++; if (cnt_a !== 16'd3) begin
      fails++; $display("FAIL b2b_cnt got %0d want 3", cnt_a); end
  endtask

  task automatic test_xaddr;
    @(negedge clk); we = 1'b0; wa = 'x; wd = 32'hFFFFFFFF;
    @(posedge clk); #1; wa = '0; ra0 = 5'd4; ra1 = 5'd7; #1;
    tests++; if (rd0_a !== 32'h3 || rd1_a !== 32'h0 || cnt_a !== 16'd3) begin
      fails++; $display("FAIL xaddr got %h %h %0d want 3 0 3", rd0_a, rd1_a, cnt_a); end
  endtask

  task automatic test_saturate;
    // wr_cnt is 3 on entry, so FFFE is reached after 65531 more writes.
    for (int i = 1; i <= 65540; i++) begin
      @(negedge clk);
      if (i == 65532) begin
        tests++; if (cnt_a !== 16'hFFFE) begin
          fails++; $display("FAIL sat_pre got %h want fffe", cnt_a); end
      end
      we = 1'b1; wa = 5'd3; wd = 32'(i);
    end
    @(posedge clk); #1; we = 1'b0; ra0 = 5'd3; #1;
    tests++; if (cnt_a !== 16'hFFFF || cnt_b !== 16'hFFFF) begin
      fails++; $display("FAIL sat_cnt got %h/%h want ffff", cnt_a, cnt_b); end
    tests++; if (rd0_a !== 32'd65540) begin
      fails++; $display("FAIL sat_data got %0d want 65540", rd0_a); end
  endtask

  initial begin
    test_reset;
    test_walk;
    test_zero_reg;
    test_rdw;
    test_mid_reset;
    test_back_to_back;
    test_xaddr;
    test_saturate;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
